uart_tx_scheduler: RTL and testbench



---
 rtl/uart_tx_scheduler.sv | 140 ++++++++++++++
 tb/tb_uart_tx_scheduler.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_scheduler.sv
// Four-source round-robin UART transmitter: start, 8 data LSB first, optional even parity (`UART_TX_SCHED_PARITY_EN), STOP_BITS stop.
// Latency: 1 Div_CLK from REQ in IDLE to GRANT and start bit; back-to-back frames repeat every F cycles with no idle gap.
// Backpressure: a requester holds REQ and its byte until GRANT; REQ is sampled only in IDLE or on the final stop-bit edge.
module uart_tx_scheduler #(
    parameter int STOP_BITS = 1
) (
    input  logic        Div_CLK,
    input  logic        RST,
    input  logic [3:0]  REQ,
    input  logic [31:0] DATA_IN,
    output logic [3:0]  GRANT,
    output logic        BUSY,
    output logic        TX
);

    localparam logic [1:0] STOP_LAST = 2'(STOP_BITS - 1);

`ifdef UART_TX_SCHED_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t      state_q, state_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic [1:0]  stop_cnt_q, stop_cnt_d;
    logic [7:0]  shreg_q, shreg_d;
    logic [1:0]  ptr_q, ptr_d;
    logic [3:0]  grant_d;
    logic        busy_d;
    logic        tx_d;
    logic        arb_pt;
    logic        arb_vld;
    logic [1:0]  arb_idx;

    // Scan offsets 4..1 so the smallest offset after ptr overrides the rest.
    always_comb begin
        arb_vld = 1'b0;
        arb_idx = 2'd0;
        for (int i = 4; i >= 1; i--) begin
            if (REQ[ptr_q + 2'(i)]) begin
                arb_vld = 1'b1;
                arb_idx = ptr_q + 2'(i);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        bit_idx_d  = bit_idx_q;
        stop_cnt_d = stop_cnt_q;
        shreg_d    = shreg_q;
        ptr_d      = ptr_q;
        grant_d    = 4'b0000;
        busy_d     = 1'b1;
        tx_d       = 1'b1;
        arb_pt     = 1'b0;

        case (state_q)
            IDLE: begin
                arb_pt = 1'b1;
            end
            START: begin
                state_d   = DATA;
                bit_idx_d = 3'd0;
                tx_d      = shreg_q[0];
            end
            DATA: begin
                if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_SCHED_PARITY_EN
                    state_d = PAR;
                    tx_d    = ^shreg_q;
`else
                    state_d    = STOP;
                    stop_cnt_d = 2'd0;
                    tx_d       = 1'b1;
`endif
                end else begin
                    bit_idx_d = bit_idx_q + 3'd1;
                    tx_d      = shreg_q[bit_idx_q + 3'd1];
                end
            end
`ifdef UART_TX_SCHED_PARITY_EN
            PAR: begin
                state_d    = STOP;
                stop_cnt_d = 2'd0;
            end
`endif
            STOP: begin
                if (stop_cnt_q == STOP_LAST) begin
                    arb_pt = 1'b1;
                end else begin
                    stop_cnt_d = stop_cnt_q + 2'd1;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase

        // Arbitrating on the last stop edge chains the next start bit with no idle cycle.
        if (arb_pt) begin
            if (arb_vld) begin
                state_d = START;
                shreg_d = DATA_IN[{arb_idx, 3'b000} +: 8];
                grant_d = 4'b0001 << arb_idx;
                ptr_d   = arb_idx;
                tx_d    = 1'b0;
            end else begin
                state_d = IDLE;
                busy_d  = 1'b0;
                tx_d    = 1'b1;
            end
        end
    end

    always_ff @(posedge Div_CLK or posedge RST) begin
        if (RST) begin
            state_q    <= IDLE;
            bit_idx_q  <= 3'd0;
            stop_cnt_q <= 2'd0;
            shreg_q    <= 8'h00;
            ptr_q      <= 2'd3;
            GRANT      <= 4'b0000;
            BUSY       <= 1'b0;
            TX         <= 1'b1;
        end else begin
            state_q    <= state_d;
            bit_idx_q  <= bit_idx_d;
            stop_cnt_q <= stop_cnt_d;
            shreg_q    <= shreg_d;
            ptr_q      <= ptr_d;
            GRANT      <= grant_d;
            BUSY       <= busy_d;
            TX         <= tx_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Bench for uart_tx_scheduler: queue-of-bits frame model checked every cycle, plus directed literal checks.
module tb_uart_tx_scheduler;

    localparam int SB = 1;
`ifdef UART_TX_SCHED_PARITY_EN
    localparam int F = 10 + SB;
`else
    localparam int F = 9 + SB;
`endif

    logic        Div_CLK = 1'b0;
    logic        RST = 1'b1;
    logic [3:0]  REQ = 4'b0000;
    logic [31:0] DATA_IN = 32'h0;
    logic [3:0]  GRANT;
    logic        BUSY;
    logic        TX;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;

    uart_tx_scheduler #(.STOP_BITS(SB)) dut (
        .Div_CLK (Div_CLK),
        .RST     (RST),
        .REQ     (REQ),
        .DATA_IN (DATA_IN),
        .GRANT   (GRANT),
        .BUSY    (BUSY),
        .TX      (TX)
    );

    always #5 Div_CLK = ~Div_CLK;
    always @(posedge Div_CLK) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Model: m_q holds the remaining line levels of the frame, m_q[0] is the one on the wire now.
    logic       m_q[$];
    int         m_ptr = 3;
    logic       m_tx = 1'b1;
    logic       m_busy = 1'b0;
    logic [3:0] m_gnt = 4'b0000;

    always @(negedge Div_CLK) begin : model
        int         w;
        logic [7:0] b;
        if (RST) begin
            m_q.delete();
            m_ptr  = 3;
            m_tx   = 1'b1;
            m_busy = 1'b0;
            m_gnt  = 4'b0000;
            chk("rst_tx", TX, 1);
            chk("rst_busy", BUSY, 0);
            chk("rst_grant", GRANT, 0);
        end else begin
            chk("tx", TX, m_tx);
            chk("busy", BUSY, m_busy);
            chk("grant", GRANT, m_gnt);
            if (m_q.size() > 1) begin
                void'(m_q.pop_front());
                m_tx   = m_q[0];
                m_busy = 1'b1;
                m_gnt  = 4'b0000;
            end else begin
                w = -1;
                for (int i = 1; i <= 4; i++)
                    if (w < 0 && REQ[(m_ptr + i) % 4]) w = (m_ptr + i) % 4;
                m_q.delete();
                if (w >= 0) begin
                    b = DATA_IN[8*w +: 8];
                    m_q.push_back(1'b0);
                    for (int k = 0; k < 8; k++) m_q.push_back(b[k]);
`ifdef UART_TX_SCHED_PARITY_EN
                    m_q.push_back(^b);
`endif
                    for (int s = 0; s < SB; s++) m_q.push_back(1'b1);
                    m_ptr  = w;
                    m_tx   = 1'b0;
                    m_busy = 1'b1;
                    m_gnt  = 4'(1 << w);
                end else begin
                    m_tx   = 1'b1;
                    m_busy = 1'b0;
                    m_gnt  = 4'b0000;
                end
            end
        end
    end

    task automatic wait_grant(output logic [3:0] g, output int at);
        g  = 4'b0000;
        at = -1;
        for (int k = 0; k < 4 * F && g == 4'b0000; k++) begin
            @(negedge Div_CLK);
            if (GRANT != 4'b0000) begin
                g  = GRANT;
                at = cyc;
            end
        end
        if (g == 4'b0000) chk("grant_timeout", {28'b0, g}, 32'h1);
    endtask

    task automatic wait_idle();
        logic seen;
        seen = 1'b0;
        for (int k = 0; k < 4 * F && !seen; k++) begin
            @(negedge Div_CLK);
            if (!BUSY) seen = 1'b1;
        end
        if (!seen) chk("idle_timeout", {31'b0, seen}, 32'h1);
    endtask

    initial begin : watchdog
        #(200000);
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin : stim
        logic [3:0]  g;
        int          at, prev, bcnt;
        logic [11:0] txv, exp_txv;

`ifdef UART_TX_SCHED_PARITY_EN
        exp_txv = 12'h52A;
`else
        exp_txv = 12'h34A;
`endif

        repeat (3) @(posedge Div_CLK);
        #2 RST = 1'b0;
        #1;
        chk("reset_tx", TX, 1);
        chk("reset_busy", BUSY, 0);
        chk("reset_grant", GRANT, 0);

        // Single source 0, byte 0xA5.
        @(posedge Div_CLK); #2;
        REQ = 4'b0001;
        DATA_IN[7:0] = 8'hA5;
        wait_grant(g, at);
        chk("t1_grant", g, 4'b0001);
        txv = '0;
        txv[0] = TX;
        bcnt = int'(BUSY);
        @(posedge Div_CLK); #2 REQ = 4'b0000;
        for (int k = 1; k < F; k++) begin
            @(negedge Div_CLK);
            txv[k] = TX;
            bcnt += int'(BUSY);
            chk("t1_grant_pulse", GRANT, 0);
        end
        chk("t1_tx_frame", txv, exp_txv);
        chk("t1_busy_cycles", bcnt, F);
        @(negedge Div_CLK);
        chk("t1_idle_tx", TX, 1);
        chk("t1_idle_busy", BUSY, 0);

        // All four requesting from reset: rotation 0,1,2,3,0 at spacing F.
        @(posedge Div_CLK); #2;
        RST = 1'b1;
        REQ = 4'b1111;
        DATA_IN = 32'h44332211;
        repeat (2) @(posedge Div_CLK);
        #2 RST = 1'b0;
        prev = 0;
        for (int i = 0; i < 5; i++) begin
            wait_grant(g, at);
            chk("t2_order", g, 4'b0001 << (i % 4));
            if (i > 0) chk("t2_spacing", at - prev, F);
            prev = at;
        end
        @(posedge Div_CLK); #2 REQ = 4'b0000;
        wait_idle();

        // Source 2 back-to-back, byte toggled on the edge after each grant.
        @(posedge Div_CLK); #2;
        REQ = 4'b0100;
        DATA_IN = 32'h0;
        for (int i = 0; i < 3; i++) begin
            wait_grant(g, at);
            chk("t3_grant", g, 4'b0100);
            if (i > 0) chk("t3_spacing", at - prev, F);
            prev = at;
            @(posedge Div_CLK); #2;
            DATA_IN[23:16] = ~DATA_IN[23:16];
            if (i == 2) REQ = 4'b0000;
        end
        wait_idle();

        // Reset during DATA bit 3 of a source-1 frame.
        @(posedge Div_CLK); #2;
        REQ = 4'b0010;
        DATA_IN[15:8] = 8'hA5;
        wait_grant(g, at);
        chk("t4_grant", g, 4'b0010);
        @(posedge Div_CLK); #2 REQ = 4'b0000;
        repeat (3) @(posedge Div_CLK);
        #1 chk("t4_pre_tx", TX, 0);
        chk("t4_pre_busy", BUSY, 1);
        #1;
        RST = 1'b1;
        REQ = 4'b0110;
        DATA_IN[15:8]  = 8'h81;
        DATA_IN[23:16] = 8'h7E;
        #1;
        chk("t4_rst_tx", TX, 1);
        chk("t4_rst_busy", BUSY, 0);
        chk("t4_rst_grant", GRANT, 0);
        repeat (2) @(posedge Div_CLK);
        #2 RST = 1'b0;
        wait_grant(g, at);
        chk("t4_first_after_rst", g, 4'b0010);
        @(posedge Div_CLK); #2 REQ = 4'b0100;
        wait_grant(g, at);
        chk("t4_second_after_rst", g, 4'b0100);
        @(posedge Div_CLK); #2 REQ = 4'b0000;
        wait_idle();

        // Source 3 raises REQ during the stop bit of a source-1 frame.
        @(posedge Div_CLK); #2;
        REQ = 4'b0010;
        DATA_IN[15:8] = 8'h5A;
        wait_grant(g, at);
        chk("t5_grant1", g, 4'b0010);
        prev = at;
        @(posedge Div_CLK); #2 REQ = 4'b0000;
        repeat (F - 2) @(posedge Div_CLK);
        #1 chk("t5_stop_tx", TX, 1);
        #1;
        REQ = 4'b1000;
        DATA_IN[31:24] = 8'hC3;
        wait_grant(g, at);
        chk("t5_grant3", g, 4'b1000);
        chk("t5_no_gap", at - prev, F);
        @(posedge Div_CLK); #2 REQ = 4'b0000;
        wait_idle();

        repeat (2) @(negedge Div_CLK);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
